// File: rtl/instr_fetch.sv
// Instruction fetch stage: fetch PC, memory req/ready read port, valid/ack hand-off to decode.
// Optional FETCH_COUNT_EN adds a saturating 32-bit count of completed fetches.
module instr_fetch #(
    parameter int unsigned       ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int unsigned       InstrWidth = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  mem_req,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic                  mem_ready,
    input  logic [InstrWidth-1:0] mem_rdata,
    output logic [InstrWidth-1:0] instr,
    output logic [ADDR_W-1:0]     instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ack,
    input  logic                  halted,
    input  logic                  redirect_en,
    input  logic [ADDR_W-1:0]     redirect_pc,
    output logic                  stopped
`ifdef FETCH_COUNT_EN
    ,
    output logic [31:0]           fetch_count
`endif
);

    typedef enum logic [1:0] {StFetch, StHold, StHalt} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       fetch_pc_q, fetch_pc_d;
    logic [InstrWidth-1:0]   instr_q, instr_d;
    logic [ADDR_W-1:0]       instr_pc_q, instr_pc_d;
    logic                    valid_q, valid_d;
    logic                    stopped_q, stopped_d;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        stopped_d  = stopped_q;
        case (state_q)
            StFetch: begin
                if (mem_ready) begin
                    instr_d    = mem_rdata;
                    instr_pc_d = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + ADDR_W'(1);
                    valid_d    = 1'b1;
                    state_d    = StHold;
                end
            end
            StHold: begin
                if (instr_ack) begin
                    valid_d = 1'b0;
                    // A halt wins over a same-cycle redirect.
                    if (halted) begin
                        state_d   = StHalt;
                        stopped_d = 1'b1;
                    end else begin
                        if (redirect_en) begin
                            fetch_pc_d = redirect_pc;
                        end
                        state_d = StFetch;
                    end
                end
            end
            StHalt: begin
                valid_d   = 1'b0;
                stopped_d = 1'b1;
            end
            default: begin
                state_d = StFetch;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StFetch;
            fetch_pc_q <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            stopped_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            stopped_q  <= stopped_d;
        end
    end

    // Gated by reset so a request in flight is dropped the moment reset asserts.
    assign mem_req     = (state_q == StFetch) && reset_n;
    assign mem_addr    = fetch_pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign stopped     = stopped_q;

`ifdef FETCH_COUNT_EN
    logic [31:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if ((state_q == StFetch) && mem_ready && (count_q != 32'hFFFF_FFFF)) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign fetch_count = count_q;
`endif

endmodule
